// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only register slave: 16-bit frames {rw, addr[6:0], data[7:0]} into five 8-bit registers.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_slave #(
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done
);

  localparam int NREG = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, OVERRUN = 2'd2} state_e;

  function automatic logic addr_ok(input logic [6:0] a);
    return (int'(a) <= MAX_ADDR) && (int'(a) < NREG);
  endfunction

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic copi_s1_q, copi_s2_q;
  logic ncs_s1_q, ncs_s2_q, ncs_s3_q;

  // ncs synchronisers idle high so reset never looks like a deselect edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
      copi_s1_q <= 1'b0; copi_s2_q <= 1'b0;
      ncs_s1_q  <= 1'b1; ncs_s2_q  <= 1'b1; ncs_s3_q  <= 1'b1;
    end else begin
      sclk_s1_q <= sclk;      sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
      copi_s1_q <= copi;      copi_s2_q <= copi_s1_q;
      ncs_s1_q  <= ncs;       ncs_s2_q  <= ncs_s1_q;  ncs_s3_q  <= ncs_s2_q;
    end
  end

  logic sclk_rise, ncs_rise, ncs_fall;
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign ncs_rise  = ncs_s2_q & ~ncs_s3_q;
  assign ncs_fall  = ~ncs_s2_q & ncs_s3_q;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [15:0]            shift_q, shift_d, shift_nx;
  logic [NREG-1:0][7:0]   regs_q, regs_d;
  logic                   frame_done_q, frame_done_d;

  assign shift_nx = {shift_q[14:0], copi_s2_q};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    regs_d       = regs_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // deselect takes priority over a coincident sclk edge
        if (ncs_rise) begin
          state_d = IDLE;
          if (cnt_q == 5'd16 && shift_q[15] && addr_ok(shift_q[14:8])) begin
            for (int i = 0; i < NREG; i++)
              if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
            frame_done_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q == 5'd16) begin
            state_d = OVERRUN;
          end else begin
            shift_d = shift_nx;
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      OVERRUN: begin
        if (ncs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      regs_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      regs_q       <= regs_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign frame_done      = frame_done_q;

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       rd_act_q, rd_act_d;
  logic [7:0] rd_sr_q, rd_sr_d;
  logic       cipo_q, cipo_d;
  logic       cipo_oe_q, cipo_oe_d;

  assign sclk_fall = sclk_s3_q & ~sclk_s2_q;

  // header is complete on the 8th rise; data leaves on falls 8..15
  always_comb begin
    rd_act_d  = rd_act_q;
    rd_sr_d   = rd_sr_q;
    cipo_d    = cipo_q;
    cipo_oe_d = cipo_oe_q;
    if (ncs_rise) begin
      rd_act_d  = 1'b0;
      cipo_d    = 1'b0;
      cipo_oe_d = 1'b0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise && cnt_q == 5'd7) begin
        rd_act_d = ~shift_nx[7];
        rd_sr_d  = '0;
        if (addr_ok(shift_nx[6:0]))
          for (int i = 0; i < NREG; i++)
            if (shift_nx[6:0] == 7'(i)) rd_sr_d = regs_q[i];
      end else if (sclk_fall && rd_act_q && cnt_q >= 5'd8 && cnt_q <= 5'd15) begin
        cipo_d    = rd_sr_q[7];
        rd_sr_d   = {rd_sr_q[6:0], 1'b0};
        cipo_oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_act_q  <= 1'b0;
      rd_sr_q   <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
    end else begin
      rd_act_q  <= rd_act_d;
      rd_sr_q   <= rd_sr_d;
      cipo_q    <= cipo_d;
      cipo_oe_q <= cipo_oe_d;
    end
  end

  assign cipo    = cipo_q;
  assign cipo_oe = cipo_oe_q;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule
